axi_wdata_router: RTL and testbench
===================================

# axi_wdata_router

Write-data router for the AXI node. It takes one routing entry per write burst from the AW decoder and steers W beats to the selected initiator port. Each entry carries a one-hot destination, an error flag, a burst length and an ID, held in an internal FIFO. The block counts beats to find the end of each burst, flags WLAST mismatches, sinks error bursts, and issues a B-response request for each sunk error burst.

## Interface
- N_INIT_PORT, 4, number of initiator ports; one-hot destination width
- FIFO_DEPTH, 8, routing entries buffered; power of two, ≥2
- LEN_WIDTH, 8, burst length field width (AXI AWLEN, beats−1)
- ID_WIDTH, 4, transaction ID width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- test_en_i  in  1  DFT mode; no functional effect
- push_valid_i  in  1  routing entry valid
- push_ready_o  out  1  FIFO can accept an entry
- push_dest_i  in  N_INIT_PORT  one-hot destination; ignored when push_err_i=1
- push_err_i  in  1  burst is decode error; sink it locally
- push_len_i  in  LEN_WIDTH  beats−1
- push_id_i  in  ID_WIDTH  AW ID
- wvalid_i  in  1  upstream W beat valid
- wlast_i  in  1  upstream WLAST
- wready_o  out  1  upstream W ready
- wvalid_o  out  N_INIT_PORT  per-port W valid
- wready_i  in  N_INIT_PORT  per-port W ready
- err_bvalid_o  out  1  error B response request
- err_bready_i  in  1  error responder accepts the request
- err_bid_o  out  ID_WIDTH  ID of the completed error burst
- wlast_mismatch_o  out  1  one-cycle pulse on a WLAST protocol violation
- fifo_count_o  out  $clog2(FIFO_DEPTH+1)  entries currently held

## Operation
- **FIFO.** Circular buffer of {dest, err, len, id} entries.
  - An entry is pushed on push_valid_i & push_ready_o.
  - push_ready_o = !full. There is no push-while-full, even when a pop happens in the same cycle.
  - The head entry is popped when the burst-end beat is accepted.
- **FSM states.** IDLE (FIFO empty), ROUTE (head is a good entry), SINK (head is an error entry), RESP (error response pending).
- **ROUTE.**
  - wvalid_o = {N{wvalid_i}} & dest.
  - wready_o = |(wready_i & dest).
  - A beat is accepted on wvalid_i & wready_o.
- **SINK.**
  - wready_o = 1 and wvalid_o = 0.
  - Beats are accepted and discarded.
- **IDLE and RESP.** wready_o = 0 and wvalid_o = 0.
- **Beat counter** (LEN_WIDTH bits).
  - Cleared when a burst ends; incremented on each accepted beat.
  - The burst-end beat is the accepted beat where count == head.len. The counter, not WLAST, is authoritative.
- **WLAST mismatch.** wlast_mismatch_o pulses on an accepted beat when wlast_i != (count == head.len). Routing still follows the counter.
- **Transitions on burst end.**
  - ROUTE pop → next state chosen from the new head: ROUTE, SINK, or IDLE if the FIFO is now empty.
  - SINK pop → RESP. The head ID is registered into err_bid_o and err_bvalid_o is set.
- **RESP.**
  - Exits on err_bready_i.
  - Goes to ROUTE, SINK or IDLE according to the current head.
  - No W beats pass while in RESP.
- **Leaving IDLE.** The FSM leaves IDLE the cycle after the push that makes the FIFO non-empty.
- **fifo_count_o.** Updated every cycle: +1 on push only, −1 on pop only, unchanged on both or neither.
- **Reset mid-burst.**
  - FIFO, counter and FSM are cleared immediately.
  - Any partially transferred burst is abandoned; upstream and downstream must also be reset.

## Timing
- **Reset values.**
  - push_ready_o = 1.
  - All other outputs are 0: wready_o, wvalid_o, err_bvalid_o, err_bid_o, wlast_mismatch_o, fifo_count_o.
- **Push-to-route latency.** 1 cycle: an entry pushed at edge k routes beats from cycle k+1. There is no fall-through.
- **Combinational paths.**
  - wready_o depends on wready_i in the same cycle.
  - wvalid_o depends on wvalid_i in the same cycle.
  - There is no path from wready_i to wvalid_o.
- **Back-to-back bursts.** A new burst's first beat can be accepted in the cycle after the previous burst-end beat, with no bubble, if the next entry is already in the FIFO.
- **Error response handshake.**
  - err_bvalid_o stays high with err_bid_o stable until err_bready_i.
  - The cycle after the handshake, wready_o can be 1 again.
- **Single-beat bursts.** len=0 bursts are routed and popped on their only beat.

## Test plan
- **Single good burst.** Push dest=4'b0100, len=3; drive 4 beats with wlast on beat 4 and wready_i=4'b0100 → wvalid_o=4'b0100 on each beat, pop after beat 4, fifo_count_o 1→0, no mismatch pulse.
- **Back-to-back bursts with backpressure.** Push dest=0001/len=0 then dest=1000/len=1; toggle wready_i bit 3 low for 2 cycles → the first beat goes to port 0, the next two beats go to port 3, wready_o=0 during the stall, no bubble after the burst end.
- **Error burst.** Push err=1, id=0x5, len=2, followed by a good entry; 3 beats → wready_o=1 and wvalid_o=0 during the burst, then err_bvalid_o=1 with err_bid_o=0x5. Hold err_bready_i=0 for 3 cycles → wready_o=0 throughout, and the good burst resumes the cycle after the handshake.
- **FIFO full.** Push FIFO_DEPTH entries with no W traffic → push_ready_o=0 and fifo_count_o=8. Accept one burst end while push_valid_i=1 → no push that cycle, push_ready_o=1 the next cycle.
- **WLAST violations.** Burst with len=1: wlast on beat 1 → mismatch pulse, and beat 2 is still routed. Burst with len=0 and wlast=0 → mismatch pulse, and the entry is popped.
- **Reset mid-burst.** Assert rst_n low after beat 2 of a 4-beat burst → all outputs return to their reset values asynchronously and fifo_count_o=0.

Source files
------------

// File: rtl/axi_wdata_router.sv
// Write-data router: buffers one routing entry per AW burst and steers W beats
// to the selected initiator port, sinking decode-error bursts and requesting B.
module axi_wdata_router #(
  parameter int unsigned N_INIT_PORT = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned ID_WIDTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               test_en_i,
  input  logic                               push_valid_i,
  output logic                               push_ready_o,
  input  logic [N_INIT_PORT-1:0]             push_dest_i,
  input  logic                               push_err_i,
  input  logic [LEN_WIDTH-1:0]               push_len_i,
  input  logic [ID_WIDTH-1:0]                push_id_i,
  input  logic                               wvalid_i,
  input  logic                               wlast_i,
  output logic                               wready_o,
  output logic [N_INIT_PORT-1:0]             wvalid_o,
  input  logic [N_INIT_PORT-1:0]             wready_i,
  output logic                               err_bvalid_o,
  input  logic                               err_bready_i,
  output logic [ID_WIDTH-1:0]                err_bid_o,
  output logic                               wlast_mismatch_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [N_INIT_PORT-1:0] dest;
    logic                   err;
    logic [LEN_WIDTH-1:0]   len;
    logic [ID_WIDTH-1:0]    id;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ROUTE, SINK, RESP} state_e;

  state_e               state_q, state_d;
  entry_t               mem [FIFO_DEPTH];
  entry_t               head;
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [LEN_WIDTH-1:0] beat_cnt_q;
  logic                 push_fire, accept, last_beat, pop;
  logic                 next_valid, next_err, cur_valid, cur_err;
  logic                 unused_test_en;

  assign unused_test_en = test_en_i;

  assign head         = mem[rd_ptr_q];
  assign push_ready_o = (fifo_count_o != CNT_W'(FIFO_DEPTH));
  assign push_fire    = push_valid_i & push_ready_o;

  // W channel steering; only ROUTE and SINK ever accept beats
  always_comb begin
    wready_o = 1'b0;
    wvalid_o = '0;
    if (state_q == ROUTE) begin
      wvalid_o = {N_INIT_PORT{wvalid_i}} & head.dest;
      wready_o = |(wready_i & head.dest);
    end else if (state_q == SINK) begin
      wready_o = 1'b1;
    end
  end

  assign accept    = wvalid_i & wready_o;
  assign last_beat = (beat_cnt_q == head.len);
  assign pop       = accept & last_beat;

  // Head seen after a pop, and head seen now; an entry pushed this cycle
  // becomes the head when the FIFO would otherwise be empty.
  always_comb begin
    next_valid = 1'b0;
    next_err   = 1'b0;
    if (fifo_count_o > CNT_W'(1)) begin
      next_valid = 1'b1;
      next_err   = mem[rd_ptr_q + PTR_W'(1)].err;
    end else if (push_fire) begin
      next_valid = 1'b1;
      next_err   = push_err_i;
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_err   = 1'b0;
    if (fifo_count_o != '0) begin
      cur_valid = 1'b1;
      cur_err   = head.err;
    end else if (push_fire) begin
      cur_valid = 1'b1;
      cur_err   = push_err_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (push_fire) state_d = push_err_i ? SINK : ROUTE;
      ROUTE: if (pop) state_d = next_valid ? (next_err ? SINK : ROUTE) : IDLE;
      SINK:  if (pop) state_d = RESP;
      RESP:  if (err_bready_i) state_d = cur_valid ? (cur_err ? SINK : ROUTE) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Entry storage; contents are qualified by the count, so no reset needed
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr_q] <= '{dest: push_dest_i, err: push_err_i,
                         len: push_len_i, id: push_id_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      fifo_count_o     <= '0;
      beat_cnt_q       <= '0;
      err_bvalid_o     <= 1'b0;
      err_bid_o        <= '0;
      wlast_mismatch_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push_fire) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_fire, pop})
        2'b10:   fifo_count_o <= fifo_count_o + CNT_W'(1);
        2'b01:   fifo_count_o <= fifo_count_o - CNT_W'(1);
        default: fifo_count_o <= fifo_count_o;
      endcase
      if (pop)         beat_cnt_q <= '0;
      else if (accept) beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
      // Registered: pulses the cycle after the offending beat
      wlast_mismatch_o <= accept & (wlast_i != last_beat);
      if (state_q == SINK && pop) begin
        err_bvalid_o <= 1'b1;
        err_bid_o    <= head.id;
      end else if (state_q == RESP && err_bready_i) begin
        err_bvalid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_wdata_router.sv
// Directed bench for axi_wdata_router: routing, back-pressure, error sink,
// FIFO full, WLAST violations and asynchronous reset mid-burst.
module tb_axi_wdata_router;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       test_en_i;
  logic       push_valid_i;
  logic       push_ready_o;
  logic [3:0] push_dest_i;
  logic       push_err_i;
  logic [7:0] push_len_i;
  logic [3:0] push_id_i;
  logic       wvalid_i;
  logic       wlast_i;
  logic       wready_o;
  logic [3:0] wvalid_o;
  logic [3:0] wready_i;
  logic       err_bvalid_o;
  logic       err_bready_i;
  logic [3:0] err_bid_o;
  logic       wlast_mismatch_o;
  logic [3:0] fifo_count_o;

  int errors = 0;
  int checks = 0;

  axi_wdata_router #(
    .N_INIT_PORT(4), .FIFO_DEPTH(8), .LEN_WIDTH(8), .ID_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_dest_i(push_dest_i), .push_err_i(push_err_i),
    .push_len_i(push_len_i), .push_id_i(push_id_i),
    .wvalid_i(wvalid_i), .wlast_i(wlast_i), .wready_o(wready_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .err_bvalid_o(err_bvalid_o), .err_bready_i(err_bready_i),
    .err_bid_o(err_bid_o), .wlast_mismatch_o(wlast_mismatch_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] dest, input logic err,
                      input logic [7:0] len, input logic [3:0] id);
    push_dest_i  = dest;
    push_err_i   = err;
    push_len_i   = len;
    push_id_i    = id;
    push_valid_i = 1'b1;
    nxt();
    push_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    test_en_i = 1'b0; push_valid_i = 1'b0; push_dest_i = '0; push_err_i = 1'b0;
    push_len_i = '0; push_id_i = '0; wvalid_i = 1'b1; wlast_i = 1'b0;
    wready_i = 4'hf; err_bready_i = 1'b0;
    #12;
    checks++; if (push_ready_o !== 1'b1) begin errors++; $display("FAIL reset_push_ready got=%b exp=1", push_ready_o); end
    checks++; if (wready_o !== 1'b0) begin errors++; $display("FAIL reset_wready got=%b exp=0", wready_o); end
    checks++; if (wvalid_o !== 4'h0) begin errors++; $display("FAIL reset_wvalid got=%h exp=0", wvalid_o); end
    checks++; if (err_bvalid_o !== 1'b0 || err_bid_o !== 4'h0) begin errors++; $display("FAIL reset_err_b got=%b/%h exp=0/0", err_bvalid_o, err_bid_o); end
    checks++; if (wlast_mismatch_o !== 1'b0) begin errors++; $display("FAIL reset_mismatch got=%b exp=0", wlast_mismatch_o); end
    checks++; if (fifo_count_o !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count_o); end
    wvalid_i = 1'b0; wready_i = 4'h0;
    mid();
    rst_n = 1'b1;
    nxt();
  endtask

  task automatic test_single_burst();
    push(4'b0100, 1'b0, 8'd3, 4'h1);
    checks++; if (fifo_count_o !== 4'd1) begin errors++; $display("FAIL single_count_push got=%0d exp=1", fifo_count_o); end
    wready_i = 4'b0100; wvalid_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wlast_i = (b == 3);
      mid();
      checks++; if (wvalid_o !== 4'b0100 || wready_o !== 1'b1) begin errors++; $display("FAIL single_beat%0d got=%b/%b exp=0100/1", b, wvalid_o, wready_o); end
      if (b > 0) begin
        checks++; if (wlast_mismatch_o !== 1'b0) begin errors++; $display("FAIL single_mismatch%0d got=%b exp=0", b, wlast_mismatch_o); end
      end
      nxt();
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    mid();
    checks++; if (fifo_count_o !== 4'd0) begin errors++; $display("FAIL single_count_pop got=%0d exp=0", fifo_count_o); end
    checks++; if (wlast_mismatch_o !== 1'b0) begin errors++; $display("FAIL single_mismatch_last got=%b exp=0", wlast_mismatch_o); end
    checks++; if (wready_o !== 1'b0) begin errors++; $display("FAIL single_idle_wready got=%b exp=0", wready_o); end
    nxt();
    wready_i = 4'h0;
  endtask

  task automatic test_back_to_back();
    push(4'b0001, 1'b0, 8'd0, 4'h2);
    push(4'b1000, 1'b0, 8'd1, 4'h3);
    checks++; if (fifo_count_o !== 4'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", fifo_count_o); end
    wready_i = 4'b1001; wvalid_i = 1'b1; wlast_i = 1'b1;
    mid();
    checks++; if (wvalid_o !== 4'b0001 || wready_o !== 1'b1) begin errors++; $display("FAIL b2b_port0 got=%b/%b exp=0001/1", wvalid_o, wready_o); end
    nxt();
    wlast_i = 1'b0; wready_i = 4'b0001;
    for (int s = 0; s < 2; s++) begin
      mid();
      checks++; if (wvalid_o !== 4'b1000 || wready_o !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d got=%b/%b exp=1000/0", s, wvalid_o, wready_o); end
      nxt();
    end
    wready_i = 4'b1001;
    mid();
    checks++; if (wvalid_o !== 4'b1000 || wready_o !== 1'b1) begin errors++; $display("FAIL b2b_port3_beat1 got=%b/%b exp=1000/1", wvalid_o, wready_o); end
    nxt();
    wlast_i = 1'b1;
    mid();
    checks++; if (wvalid_o !== 4'b1000 || wready_o !== 1'b1) begin errors++; $display("FAIL b2b_port3_beat2 got=%b/%b exp=1000/1", wvalid_o, wready_o); end
    nxt();
    wvalid_i = 1'b0; wlast_i = 1'b0;
    mid();
    checks++; if (fifo_count_o !== 4'd0 || wlast_mismatch_o !== 1'b0) begin errors++; $display("FAIL b2b_end got=%0d/%b exp=0/0", fifo_count_o, wlast_mismatch_o); end
    nxt();
    wready_i = 4'h0;
  endtask

  task automatic test_error_burst();
    push(4'b0000, 1'b1, 8'd2, 4'h5);
    push(4'b0010, 1'b0, 8'd0, 4'h6);
    wvalid_i = 1'b1; wready_i = 4'h0;
    for (int b = 0; b < 3; b++) begin
      wlast_i = (b == 2);
      mid();
      checks++; if (wready_o !== 1'b1 || wvalid_o !== 4'h0) begin errors++; $display("FAIL err_sink%0d got=%b/%b exp=1/0000", b, wready_o, wvalid_o); end
      nxt();
    end
    wready_i = 4'b0010; wlast_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mid();
      checks++; if (err_bvalid_o !== 1'b1 || err_bid_o !== 4'h5) begin errors++; $display("FAIL err_resp%0d got=%b/%h exp=1/5", c, err_bvalid_o, err_bid_o); end
      checks++; if (wready_o !== 1'b0 || wvalid_o !== 4'h0) begin errors++; $display("FAIL err_hold%0d got=%b/%b exp=0/0000", c, wready_o, wvalid_o); end
      nxt();
    end
    err_bready_i = 1'b1;
    mid();
    checks++; if (err_bvalid_o !== 1'b1 || wready_o !== 1'b0) begin errors++; $display("FAIL err_handshake got=%b/%b exp=1/0", err_bvalid_o, wready_o); end
    nxt();
    err_bready_i = 1'b0;
    mid();
    checks++; if (err_bvalid_o !== 1'b0) begin errors++; $display("FAIL err_bvalid_clear got=%b exp=0", err_bvalid_o); end
    checks++; if (wready_o !== 1'b1 || wvalid_o !== 4'b0010) begin errors++; $display("FAIL err_resume got=%b/%b exp=1/0010", wready_o, wvalid_o); end
    nxt();
    wvalid_i = 1'b0; wlast_i = 1'b0;
    mid();
    checks++; if (fifo_count_o !== 4'd0) begin errors++; $display("FAIL err_count got=%0d exp=0", fifo_count_o); end
    nxt();
    wready_i = 4'h0;
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 8; i++) push(4'b0001, 1'b0, 8'd0, 4'(i));
    mid();
    checks++; if (fifo_count_o !== 4'd8 || push_ready_o !== 1'b0) begin errors++; $display("FAIL full_state got=%0d/%b exp=8/0", fifo_count_o, push_ready_o); end
    nxt();
    push_dest_i = 4'b0010; push_err_i = 1'b0; push_len_i = 8'd0; push_id_i = 4'hf;
    push_valid_i = 1'b1; wvalid_i = 1'b1; wready_i = 4'b0001; wlast_i = 1'b1;
    mid();
    checks++; if (push_ready_o !== 1'b0 || wready_o !== 1'b1) begin errors++; $display("FAIL full_pop_cycle got=%b/%b exp=0/1", push_ready_o, wready_o); end
    nxt();
    push_valid_i = 1'b0; wvalid_i = 1'b0;
    mid();
    checks++; if (fifo_count_o !== 4'd7 || push_ready_o !== 1'b1) begin errors++; $display("FAIL full_after_pop got=%0d/%b exp=7/1", fifo_count_o, push_ready_o); end
    nxt();
    wvalid_i = 1'b1;
    for (int i = 0; i < 7; i++) nxt();
    wvalid_i = 1'b0; wlast_i = 1'b0;
    mid();
    checks++; if (fifo_count_o !== 4'd0) begin errors++; $display("FAIL full_drain got=%0d exp=0", fifo_count_o); end
    nxt();
    wready_i = 4'h0;
  endtask

  task automatic test_wlast_violation();
    push(4'b0001, 1'b0, 8'd1, 4'h7);
    wvalid_i = 1'b1; wready_i = 4'b0001; wlast_i = 1'b1;
    nxt();
    mid();
    checks++; if (wlast_mismatch_o !== 1'b1) begin errors++; $display("FAIL wl_early_pulse got=%b exp=1", wlast_mismatch_o); end
    checks++; if (wvalid_o !== 4'b0001 || wready_o !== 1'b1) begin errors++; $display("FAIL wl_beat2_routed got=%b/%b exp=0001/1", wvalid_o, wready_o); end
    nxt();
    wvalid_i = 1'b0; wlast_i = 1'b0;
    mid();
    checks++; if (wlast_mismatch_o !== 1'b0 || fifo_count_o !== 4'd0) begin errors++; $display("FAIL wl_early_end got=%b/%0d exp=0/0", wlast_mismatch_o, fifo_count_o); end
    nxt();
    push(4'b0100, 1'b0, 8'd0, 4'h8);
    wready_i = 4'b0100; wvalid_i = 1'b1; wlast_i = 1'b0;
    mid();
    checks++; if (wvalid_o !== 4'b0100) begin errors++; $display("FAIL wl_single_routed got=%b exp=0100", wvalid_o); end
    nxt();
    wvalid_i = 1'b0;
    mid();
    checks++; if (wlast_mismatch_o !== 1'b1) begin errors++; $display("FAIL wl_missing_pulse got=%b exp=1", wlast_mismatch_o); end
    checks++; if (fifo_count_o !== 4'd0 || wready_o !== 1'b0) begin errors++; $display("FAIL wl_missing_popped got=%0d/%b exp=0/0", fifo_count_o, wready_o); end
    nxt();
    mid();
    checks++; if (wlast_mismatch_o !== 1'b0) begin errors++; $display("FAIL wl_pulse_width got=%b exp=0", wlast_mismatch_o); end
    nxt();
    wready_i = 4'h0;
  endtask

  task automatic test_reset_mid_burst();
    push(4'b0010, 1'b0, 8'd3, 4'h9);
    wvalid_i = 1'b1; wready_i = 4'b0010; wlast_i = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b0;
    #1;
    checks++; if (wready_o !== 1'b0 || wvalid_o !== 4'h0) begin errors++; $display("FAIL rst_mid_w got=%b/%b exp=0/0000", wready_o, wvalid_o); end
    checks++; if (fifo_count_o !== 4'd0 || push_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_fifo got=%0d/%b exp=0/1", fifo_count_o, push_ready_o); end
    checks++; if (err_bvalid_o !== 1'b0 || err_bid_o !== 4'h0 || wlast_mismatch_o !== 1'b0) begin errors++; $display("FAIL rst_mid_regs got=%b/%h/%b exp=0/0/0", err_bvalid_o, err_bid_o, wlast_mismatch_o); end
    wvalid_i = 1'b0;
    mid();
    rst_n = 1'b1;
    nxt();
    push(4'b0001, 1'b0, 8'd0, 4'h1);
    wready_i = 4'b0001; wvalid_i = 1'b1; wlast_i = 1'b1;
    mid();
    checks++; if (wvalid_o !== 4'b0001) begin errors++; $display("FAIL rst_mid_reroute got=%b exp=0001", wvalid_o); end
    nxt();
    wvalid_i = 1'b0; wlast_i = 1'b0;
    mid();
    checks++; if (fifo_count_o !== 4'd0 || wlast_mismatch_o !== 1'b0) begin errors++; $display("FAIL rst_mid_counter got=%0d/%b exp=0/0", fifo_count_o, wlast_mismatch_o); end
    nxt();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_error_burst();
    test_fifo_full();
    test_wlast_violation();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
